// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause-22 MDIO management master: MDC generation and 64-bit frame serialiser
module mdio_master #(
  parameter int CLK_DIV = 50
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        mdc_o,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF     = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] HALF_M1  = DW'(CLK_DIV / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_TAIL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic [63:0]   frame_q, frame_d;
  logic          read_q, read_d;
  logic          mdc_q, mdc_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_t_q, mdio_t_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   rdata_q, rdata_d;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    read_d   = read_q;
    mdio_o_d = mdio_o_q;
    mdio_t_d = mdio_t_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    sync1_d  = mdio_i;
    sync2_d  = sync1_q;

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (cmd_valid) begin
          state_d  = S_FRAME;
          read_d   = ~cmd_write;
          // Read frames carry 1s in TA/DATA; those bits are never driven (mdio_t=1).
          frame_d  = {32'hFFFF_FFFF, 2'b01, (cmd_write ? 2'b01 : 2'b10),
                      cmd_phy_addr, cmd_reg_addr, (cmd_write ? 2'b10 : 2'b11),
                      (cmd_write ? cmd_wdata : 16'hFFFF)};
          mdio_o_d = 1'b1;
          mdio_t_d = 1'b0;
        end
      end
      S_FRAME: begin
        div_d = div_q + 1'b1;
        if (div_q == HALF_M1 && bit_q >= 6'd48) begin
          shift_d = {shift_q[14:0], sync2_q};
        end
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == 6'd63) begin
            state_d  = S_TAIL;
            mdio_o_d = 1'b1;
            mdio_t_d = 1'b1;
          end else begin
            bit_d    = bit_q + 6'd1;
            frame_d  = {frame_q[62:0], frame_q[63]};
            mdio_o_d = frame_q[62];
            // Release the line from bit 46 (TA) onward on reads.
            mdio_t_d = read_q && (bit_q >= 6'd45);
          end
        end
      end
      S_TAIL: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_DONE;
          if (read_q) begin
            rdata_d = shift_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mdc_d = (state_d == S_FRAME) && (div_d >= HALF);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      read_q   <= 1'b0;
      mdc_q    <= 1'b0;
      mdio_o_q <= 1'b1;
      mdio_t_q <= 1'b1;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      shift_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      read_q   <= read_d;
      mdc_q    <= mdc_d;
      mdio_o_q <= mdio_o_d;
      mdio_t_q <= mdio_t_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;
  assign mdc_o     = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;

endmodule
